// File: rtl/ntt_route_mux.sv
// rtl/ntt_route_mux.sv - registered N:1 coefficient router with 2-entry skid buffer
// Optional feature macro: NTT_ROUTE_MUX_AUTOSEL_EN (internal round-robin select counter).
module ntt_route_mux #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 6,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    input  logic                  err_clr
);

    generate
        if (N_IN < 2 || N_IN > 16) begin : g_bad_n_in
            $error("ntt_route_mux: N_IN must be in 2..16");
        end
        if ((1 << SEL_W) < N_IN) begin : g_bad_sel_w
            $error("ntt_route_mux: SEL_W too narrow for N_IN");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e             state_q;
    logic [WIDTH-1:0] or_data_q;
    logic [WIDTH-1:0] sk_data_q;
    logic [SEL_W-1:0] or_idx_q;
    logic [SEL_W-1:0] sk_idx_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             sel_err_q;
    logic             sel_err_d;

    logic [SEL_W-1:0] sel;
    logic             legal;
    logic             accept;
    logic             load;
    logic             drain;
    logic [WIDTH-1:0] lane_data;

    assign accept = in_valid && in_ready_q;
    assign load   = accept && legal;
    assign drain  = out_valid_q && out_ready;

`ifdef NTT_ROUTE_MUX_AUTOSEL_EN
    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;
    logic             unused_in_sel;

    assign unused_in_sel = ^in_sel;
    assign sel           = cnt_q;
    assign legal         = 1'b1;

    // The counter steps on every accepted beat, so lanes stream round-robin.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = (cnt_q == SEL_W'(N_IN - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign sel   = in_sel;
    assign legal = (32'(sel) < N_IN);
`endif

    // Out-of-range selects resolve to zero so unused lanes never leak X.
    always_comb begin
        lane_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (32'(sel) == k) begin
                lane_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            or_data_q   <= '0;
            or_idx_q    <= '0;
            sk_data_q   <= '0;
            sk_idx_q    <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        or_data_q   <= lane_data;
                        or_idx_q    <= sel;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (load && !drain) begin
                        sk_data_q  <= lane_data;
                        sk_idx_q   <= sel;
                        in_ready_q <= 1'b0;
                        state_q    <= TWO;
                    end else if (load && drain) begin
                        or_data_q <= lane_data;
                        or_idx_q  <= sel;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can move the state.
                    if (drain) begin
                        or_data_q  <= sk_data_q;
                        or_idx_q   <= sk_idx_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // A new illegal beat outranks a simultaneous clear.
    always_comb begin
        sel_err_d = sel_err_q;
        if (accept && !legal) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = or_data_q;
    assign out_idx   = or_idx_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_ntt_route_mux.sv
// tb/tb_ntt_route_mux.sv - directed and random checks of ntt_route_mux against a queue model
module tb_ntt_route_mux;

    localparam int WIDTH = 16;
    localparam int N_IN  = 6;
    localparam int SEL_W = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_idx;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;
    logic                  err_clr;

    ntt_route_mux #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] i;
    } beat_t;

    beat_t mq[$];
    bit    m_rdy;
    bit    m_err;
    bit    m_acc;
    int    m_nacc;
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [N_IN*WIDTH-1:0] rand_lanes();
        logic [N_IN*WIDTH-1:0] v;
        for (int k = 0; k < N_IN; k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    // Reference: held beats form a FIFO of depth two; ready means fewer than two held.
    task automatic step();
        beat_t b;
        int    s;
        bit    drn;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_rdy  = 1'b1;
            m_err  = 1'b0;
            m_acc  = 1'b0;
            m_nacc = 0;
        end else begin
            m_acc = in_valid && m_rdy;
            drn   = (mq.size() != 0) && out_ready;
`ifdef NTT_ROUTE_MUX_AUTOSEL_EN
            s = m_nacc % N_IN;
`else
            s = int'(in_sel);
`endif
            if (drn) mq.delete(0);
            if (m_acc) begin
                m_nacc++;
                if (s < N_IN) begin
                    b.d = WIDTH'(in_data >> (s * WIDTH));
                    b.i = SEL_W'(s);
                    mq.push_back(b);
                end
            end
            if (m_acc && s >= N_IN) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_rdy = (mq.size() < 2);
        end
        #1;
    endtask

    task automatic check(input string tag);
        bit exp_v;
        exp_v = (mq.size() != 0);
        n_tests++;
        assert (out_valid === exp_v) else begin
            n_fail++;
            $error("FAIL %s out_valid: got %0b expected %0b", tag, out_valid, exp_v);
        end
        n_tests++;
        assert (in_ready === m_rdy) else begin
            n_fail++;
            $error("FAIL %s in_ready: got %0b expected %0b", tag, in_ready, m_rdy);
        end
        n_tests++;
        assert (sel_err === m_err) else begin
            n_fail++;
            $error("FAIL %s sel_err: got %0b expected %0b", tag, sel_err, m_err);
        end
        if (exp_v) begin
            n_tests++;
            assert (out_data === mq[0].d) else begin
                n_fail++;
                $error("FAIL %s out_data: got %h expected %h", tag, out_data, mq[0].d);
            end
            n_tests++;
            assert (out_idx === mq[0].i) else begin
                n_fail++;
                $error("FAIL %s out_idx: got %0d expected %0d", tag, out_idx, mq[0].i);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;

        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        step();
        step();
        check("reset");
        n_tests++;
        assert (out_data === '0) else begin
            n_fail++;
            $error("FAIL reset out_data: got %h expected 0", out_data);
        end
        n_tests++;
        assert (out_idx === '0) else begin
            n_fail++;
            $error("FAIL reset out_idx: got %0d expected 0", out_idx);
        end
        rst_n = 1'b1;
        step();
        check("idle");

        // Streaming lanes 1..6 with out_ready high: one beat per cycle.
        for (int k = 0; k < N_IN; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
        out_ready = 1'b1;
        for (int s = 0; s < N_IN; s++) begin
            in_valid = 1'b1;
            in_sel   = SEL_W'(s);
            step();
            check("stream");
        end
        in_valid = 1'b0;
        step();
        check("stream_tail");
        step();
        check("stream_idle");

        // Backpressure: four beats offered while the sink stalls.
        out_ready = 1'b0;
        sent = 0;
        cyc  = 0;
        while (sent < 4 && cyc < 40) begin
            in_valid = 1'b1;
            in_sel   = SEL_W'(sent);
            in_data  = rand_lanes();
            if (cyc == 6) out_ready = 1'b1;
            step();
            check("backpressure");
            if (m_acc) sent++;
            cyc++;
        end
        n_tests++;
        assert (sent == 4) else begin
            n_fail++;
            $error("FAIL bp_timeout: accepted %0d expected 4", sent);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("bp_drain");
        end

        // Illegal selects, clear, and clear colliding with a new illegal beat.
        in_valid = 1'b1; in_sel = 3'd7; in_data = rand_lanes();
        step();
        check("illegal");
        in_valid = 1'b0;
        step();
        check("illegal_hold");
        err_clr = 1'b1;
        step();
        check("err_clr");
        in_valid = 1'b1; in_sel = 3'd6;
        step();
        check("clr_vs_set");
        in_valid = 1'b0; err_clr = 1'b0;
        step();
        check("clr_vs_set_after");

        // Fill both entries, then reset mid-operation.
        out_ready = 1'b0;
        cyc = 0;
        while (mq.size() < 2 && cyc < 10) begin
            in_valid = 1'b1;
            in_sel   = SEL_W'($urandom_range(0, N_IN - 1));
            in_data  = rand_lanes();
            step();
            check("fill");
            cyc++;
        end
        n_tests++;
        assert (mq.size() == 2) else begin
            n_fail++;
            $error("FAIL fill_timeout: held %0d expected 2", mq.size());
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check("mid_reset");
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_reset");

        // Random traffic with occasional illegal selects and clears.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = ($urandom_range(0, 7) == 0) ? SEL_W'($urandom_range(N_IN, 7))
                                                     : SEL_W'($urandom_range(0, N_IN - 1));
            in_data   = rand_lanes();
            out_ready = ($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            step();
            check("random");
        end
        in_valid = 1'b0; err_clr = 1'b0;

`ifdef NTT_ROUTE_MUX_AUTOSEL_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < N_IN; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(16'h0100 + k);
        for (int b = 0; b < 8; b++) begin
            in_valid = 1'b1;
            in_sel   = 3'd5;
            step();
            check("autosel");
        end
        in_valid = 1'b0;
        step();
        check("autosel_tail");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
